// File: rtl/filter_ctrl.sv
// Sequencing controller for the Q15 averaging filter: gates the filter clock-enable,
// clears it on start, discards settling outputs, decimates and buffers results.
module filter_ctrl #(
  parameter int DECIM      = 64,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        flt_rst_n,
  output logic        flt_ce,
  output logic [15:0] flt_data,
  input  logic [15:0] flt_avg,
  input  logic        flt_rdy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        overflow
);

  // state   | meaning
  // IDLE    | stopped, filter inputs ignored
  // CLEAR   | one-cycle filter reset, counters and overflow cleared
  // SETTLE  | forwarding samples, discarding the first SETTLE outputs
  // RUN     | forwarding samples, pushing every DECIM-th output
  // DRAIN   | forwarding stopped, waiting for the FIFO to empty
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam int          AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH       = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DECIM_LAST  = 16'(DECIM - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);

  logic [2:0]    state;
  logic          rst_done;
  logic [7:0]    scnt;
  logic [15:0]   dcnt;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic full;
  logic pop;
  logic push_req;
  logic push_ok;
  logic fwd;

  always_comb begin
    full     = (count == DEPTH);
    pop      = out_valid && out_ready;
    push_req = (state == S_RUN) && flt_rdy && (dcnt == DECIM_LAST);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_ok  = push_req && (!full || pop);
    // CLEAR is included so the sample arriving as the filter leaves reset is not lost.
    fwd      = in_valid && enable &&
               ((state == S_CLEAR) || (state == S_SETTLE) || (state == S_RUN));
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = (state != S_IDLE);
  assign flt_rst_n = rst_done && (state != S_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (enable) state <= S_CLEAR;
        S_CLEAR:  state <= (SETTLE > 0) ? S_SETTLE : S_RUN;
        S_SETTLE: begin
          if (!enable)
            state <= S_DRAIN;
          else if (flt_rdy && (scnt == SETTLE_LAST))
            state <= S_RUN;
        end
        S_RUN:    if (!enable) state <= S_DRAIN;
        S_DRAIN:  if (count == '0) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      scnt     <= '0;
      dcnt     <= '0;
      overflow <= 1'b0;
      flt_ce   <= 1'b0;
      flt_data <= '0;
    end else begin
      rst_done <= 1'b1;
      flt_ce   <= fwd;
      if (fwd) flt_data <= in_data;

      if (state == S_CLEAR) begin
        scnt     <= '0;
        dcnt     <= '0;
        overflow <= 1'b0;
      end else begin
        if ((state == S_SETTLE) && flt_rdy) scnt <= scnt + 8'd1;
        if ((state == S_RUN) && flt_rdy)
          dcnt <= (dcnt == DECIM_LAST) ? '0 : dcnt + 16'd1;
        if (push_req && full && !pop) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= flt_avg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_ctrl.sv
// Directed bench for filter_ctrl with DECIM=4, SETTLE=2, FIFO_DEPTH=4 and a
// filter stub that answers each clock-enable with rdy one cycle later, avg = data.
module tb_filter_ctrl;
  localparam int DECIM      = 4;
  localparam int SETTLE     = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable    = 1'b0;
  logic        in_valid  = 1'b0;
  logic [15:0] in_data   = '0;
  logic        flt_rst_n;
  logic        flt_ce;
  logic [15:0] flt_data;
  logic [15:0] flt_avg   = '0;
  logic        flt_rdy   = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
  logic        overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] got[$];

  filter_ctrl #(.DECIM(DECIM), .SETTLE(SETTLE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .flt_rst_n(flt_rst_n), .flt_ce(flt_ce), .flt_data(flt_data), .flt_avg(flt_avg),
    .flt_rdy(flt_rdy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    flt_rdy <= flt_ce;
    flt_avg <= flt_data;
  end

  // Inputs are final when step is called; a pop is recorded before the edge that takes it.
  task automatic step();
    if (out_valid && out_ready) got.push_back(out_data);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({flt_rst_n, flt_ce, out_valid, busy, overflow} !== 5'b00000)
      $display("FAIL reset_flags: got %b want 00000", {flt_rst_n, flt_ce, out_valid, busy, overflow});
    else pass_cnt++;
    total_cnt++;
    if ({flt_data, out_data} !== 32'h0)
      $display("FAIL reset_data: got %h want 00000000", {flt_data, out_data});
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({flt_rst_n, busy} !== 2'b10)
      $display("FAIL post_reset: got flt_rst_n,busy=%b want 10", {flt_rst_n, busy});
    else pass_cnt++;
    enable = 1'b1;
    step();
    total_cnt++;
    if ({flt_rst_n, busy, flt_ce} !== 3'b010)
      $display("FAIL clear_cycle: got flt_rst_n,busy,flt_ce=%b want 010", {flt_rst_n, busy, flt_ce});
    else pass_cnt++;
  endtask

  task automatic test_settle_decim();
    logic [15:0] qv [4] = '{16'h4000, 16'h2000, 16'h0000, 16'h8000};
    out_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = qv[k % 4];
      step();
      if (k == 0) begin
        total_cnt++;
        if ({flt_rst_n, flt_ce, flt_data} !== {2'b11, 16'h4000})
          $display("FAIL first_fwd: got %b %b %h want 1 1 4000", flt_rst_n, flt_ce, flt_data);
        else pass_cnt++;
      end
      in_valid = 1'b0;
      step();
    end
    repeat (3) step();
    total_cnt++;
    if (got.size() != 2) $display("FAIL decim_count: got %0d want 2", got.size());
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (i >= got.size() || got[i] !== 16'h2000)
        $display("FAIL decim_value%0d: got %h want 2000", i, (i < got.size()) ? got[i] : 16'hxxxx);
      else pass_cnt++;
    end
    total_cnt++;
    if ({out_valid, overflow} !== 2'b00)
      $display("FAIL decim_idle: got out_valid,overflow=%b want 00", {out_valid, overflow});
    else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp [5] = '{16'd1004, 16'd1008, 16'd1012, 16'd1016, 16'd1020};
    out_ready = 1'b0;
    got.delete();
    for (int i = 1; i <= 19; i++) send(16'(1000 + i));
    total_cnt++;
    if ({out_valid, overflow, out_data} !== {2'b10, 16'd1004})
      $display("FAIL full_state: got %b %b %0d want 1 0 1004", out_valid, overflow, out_data);
    else pass_cnt++;
    send(16'd1020);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total_cnt++;
    if ({out_valid, overflow, out_data} !== {2'b10, 16'd1008})
      $display("FAIL push_pop_full: got %b %b %0d want 1 0 1008", out_valid, overflow, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (6) step();
    total_cnt++;
    if (got.size() != 5) $display("FAIL push_pop_count: got %0d want 5", got.size());
    else pass_cnt++;
    foreach (exp[i]) begin
      total_cnt++;
      if (i >= got.size() || got[i] !== exp[i])
        $display("FAIL push_pop_order%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : 16'hxxxx, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp [4] = '{16'd2004, 16'd2008, 16'd2012, 16'd2016};
    out_ready = 1'b0;
    got.delete();
    for (int i = 1; i <= 24; i++) begin
      send(16'(2000 + i));
      if (i == 18) begin
        total_cnt++;
        if ({out_valid, overflow} !== 2'b10)
          $display("FAIL full_no_ovf: got out_valid,overflow=%b want 10", {out_valid, overflow});
        else pass_cnt++;
      end
    end
    repeat (2) step();
    total_cnt++;
    if ({overflow, out_data} !== {1'b1, 16'd2004})
      $display("FAIL overflow_set: got %b %0d want 1 2004", overflow, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (6) step();
    total_cnt++;
    if (got.size() != 4) $display("FAIL ovf_drain_count: got %0d want 4", got.size());
    else pass_cnt++;
    foreach (exp[i]) begin
      total_cnt++;
      if (i >= got.size() || got[i] !== exp[i])
        $display("FAIL ovf_order%0d: got %0d want %0d", i, (i < got.size()) ? got[i] : 16'hxxxx, exp[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({out_valid, overflow} !== 2'b01)
      $display("FAIL ovf_sticky: got out_valid,overflow=%b want 01", {out_valid, overflow});
    else pass_cnt++;
  endtask

  task automatic test_stop_drain();
    out_ready = 1'b0;
    got.delete();
    for (int i = 1; i <= 11; i++) send(16'(3000 + i));
    in_valid = 1'b1;
    in_data  = 16'd3012;
    step();
    in_data = 16'd3013;
    enable  = 1'b0;
    step();
    total_cnt++;
    if ({flt_ce, busy, out_valid, flt_data} !== {3'b011, 16'd3012})
      $display("FAIL stop_ce: got %b %b %b %0d want 0 1 1 3012", flt_ce, busy, out_valid, flt_data);
    else pass_cnt++;
    in_valid = 1'b0;
    enable   = 1'b1;
    step();
    total_cnt++;
    if ({busy, flt_rst_n, flt_ce} !== 3'b110)
      $display("FAIL drain_hold: got busy,flt_rst_n,flt_ce=%b want 110", {busy, flt_rst_n, flt_ce});
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (2) step();
    total_cnt++;
    if ({out_valid, busy} !== 2'b01)
      $display("FAIL drain_empty: got out_valid,busy=%b want 01", {out_valid, busy});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({busy, overflow, flt_rst_n} !== 3'b011)
      $display("FAIL drain_idle: got busy,overflow,flt_rst_n=%b want 011", {busy, overflow, flt_rst_n});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({busy, flt_rst_n} !== 2'b10)
      $display("FAIL restart_clear: got busy,flt_rst_n=%b want 10", {busy, flt_rst_n});
    else pass_cnt++;
    total_cnt++;
    if (got.size() != 2 || got[0] !== 16'd3004 || got[1] !== 16'd3008)
      $display("FAIL drain_data: got %0d entries first %0d want 2 entries 3004 3008",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({overflow, flt_rst_n, busy} !== 3'b011)
      $display("FAIL clear_ovf: got overflow,flt_rst_n,busy=%b want 011", {overflow, flt_rst_n, busy});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    got.delete();
    for (int i = 1; i <= 14; i++) send(16'(4000 + i));
    step();
    total_cnt++;
    if ({out_valid, out_data} !== {1'b1, 16'd4006})
      $display("FAIL mid_queued: got %b %0d want 1 4006", out_valid, out_data);
    else pass_cnt++;
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    step();
    total_cnt++;
    if ({out_valid, flt_ce, busy, overflow, flt_rst_n, flt_data} !== 21'h0)
      $display("FAIL mid_reset: got %b%b%b%b%b %h want 00000 0000",
               out_valid, flt_ce, busy, overflow, flt_rst_n, flt_data);
    else pass_cnt++;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    total_cnt++;
    if ({out_valid, busy, flt_rst_n} !== 3'b001)
      $display("FAIL mid_release: got out_valid,busy,flt_rst_n=%b want 001", {out_valid, busy, flt_rst_n});
    else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_settle_decim();
    test_full_push_pop();
    test_overflow();
    test_stop_drain();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
